shift_tap_reg: RTL and testbench

Parametrised shift register with selectable tap output. Generalises the fixed 8-bit serial-in shifter/tap mux to any width and adds the following:
- Four operating modes: shift left, shift right, rotate left, parallel load.
- A serial-out bit.
- A registered tap.
- A shift counter that flags when a full word has been shifted through.

It sits in the Pre-stage datapath as the general serial/parallel converter and bit-picker.

---
 rtl/shift_tap_pkg.sv | 12 +
 rtl/tap_mux.sv | 20 ++
 rtl/shift_tap_reg.sv | 113 +++++++++++
 tb/tb_shift_tap_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/shift_tap_pkg.sv
// shift_tap_pkg: shared mode encoding for the
// serial/parallel shift-tap register.
package shift_tap_pkg;

  typedef enum logic [1:0] {
    MODE_SHL  = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_ROL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/tap_mux.sv
// tap_mux: WIDTH-to-1 bit picker with range check,
// returns 0 for any select at or beyond WIDTH.
module tap_mux #(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] i_d,
  input  logic [SEL_W-1:0] i_sel,
  output logic             o_bit
);

  // compare against every legal index; no match leaves 0
  always_comb begin
    o_bit = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_sel == SEL_W'(i)) o_bit = i_d[i];
    end
  end

endmodule

// File: rtl/shift_tap_reg.sv
// shift_tap_reg: shift/rotate/load register with
// combinational and registered taps, serial out and counter.
module shift_tap_reg
  import shift_tap_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SEL_W = $clog2(WIDTH),
  parameter int CNT_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] load_data,
  input  logic [SEL_W-1:0] sel,
  output logic [WIDTH-1:0] q,
  output logic             z,
  output logic             z_r,
  output logic             sout,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);

  logic [WIDTH-1:0] r_q;
  logic             r_z;
  logic             r_sout;
  logic [CNT_W-1:0] r_cnt;
  logic             r_full;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_z_nxt;

  assign w_cnt_inc = (r_cnt == CNT_MAX) ?
                     r_cnt : r_cnt + 1'b1;

  // next-state for data, serial out and counter
  always_comb begin
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout;
    w_cnt_nxt  = r_cnt;
    if (en) begin
      case (mode_t'(mode))
        MODE_SHL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], sin};
          w_sout_nxt = r_q[WIDTH-1];
          w_cnt_nxt  = w_cnt_inc;
        end
        MODE_SHR: begin
          w_q_nxt    = {sin, r_q[WIDTH-1:1]};
          w_sout_nxt = r_q[0];
          w_cnt_nxt  = w_cnt_inc;
        end
        MODE_ROL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_sout_nxt = r_q[WIDTH-1];
        end
        default: begin
          w_q_nxt    = load_data;
          w_sout_nxt = 1'b0;
          w_cnt_nxt  = '0;
        end
      endcase
    end
  end

  tap_mux #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_tap_now (
    .i_d   (r_q),
    .i_sel (sel),
    .o_bit (z)
  );

  tap_mux #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_tap_nxt (
    .i_d   (w_q_nxt),
    .i_sel (sel),
    .o_bit (w_z_nxt)
  );

  // state registers; z_r samples every cycle, even on hold
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q    <= '0;
      r_z    <= 1'b0;
      r_sout <= 1'b0;
      r_cnt  <= '0;
      r_full <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_z    <= w_z_nxt;
      r_sout <= w_sout_nxt;
      r_cnt  <= w_cnt_nxt;
      r_full <= (w_cnt_nxt == CNT_MAX);
    end
  end

  assign q    = r_q;
  assign z_r  = r_z;
  assign sout = r_sout;
  assign cnt  = r_cnt;
  assign full = r_full;

endmodule

// File: tb/tb_shift_tap_reg.sv
// tb_shift_tap_reg: directed checks on WIDTH=8 and
// WIDTH=6 instances with hand-computed expectations.
module tb_shift_tap_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       rst_n, en, sin;
  logic [1:0] mode;
  logic [7:0] ld;
  logic [2:0] sel;
  logic [7:0] q;
  logic       z, z_r, sout, full;
  logic [3:0] cnt;

  shift_tap_reg #(.WIDTH(8)) u_dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .mode      (mode),
    .sin       (sin),
    .load_data (ld),
    .sel       (sel),
    .q         (q),
    .z         (z),
    .z_r       (z_r),
    .sout      (sout),
    .cnt       (cnt),
    .full      (full)
  );

  // WIDTH=6 instance
  logic       rst6_n, en6, sin6;
  logic [1:0] mode6;
  logic [5:0] ld6;
  logic [2:0] sel6;
  logic [5:0] q6;
  logic       z6, z6_r, sout6, full6;
  logic [2:0] cnt6;

  shift_tap_reg #(.WIDTH(6)) u_dut6 (
    .clk       (clk),
    .rst_n     (rst6_n),
    .en        (en6),
    .mode      (mode6),
    .sin       (sin6),
    .load_data (ld6),
    .sel       (sel6),
    .q         (q6),
    .z         (z6),
    .z_r       (z6_r),
    .sout      (sout6),
    .cnt       (cnt6),
    .full      (full6)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] pat;
  logic [7:0] v5a;
  logic [2:0] exp_sout;

  initial begin
    pat      = 8'b1011_0010;
    v5a      = 8'h5A;
    exp_sout = 3'b101;

    rst_n = 1'b0; en = 1'b1; mode = 2'b00;
    sin = 1'b1; ld = '0; sel = '0;
    rst6_n = 1'b0; en6 = 1'b0; mode6 = 2'b00;
    sin6 = 1'b0; ld6 = '0; sel6 = '0;
    #2;
    step();
    chk("rst_q", q, 8'h00);
    chk("rst_cnt", cnt, 4'd0);
    chk("rst_full", full, 1'b0);
    chk("rst_sout", sout, 1'b0);
    chk("rst_zr", z_r, 1'b0);
    rst_n = 1'b1;
    rst6_n = 1'b1;

    // serial-in 1,0,1,1,0,0,1,0 (MSB first)
    mode = 2'b00;
    for (int i = 7; i >= 0; i--) begin
      sin = pat[i];
      step();
      if (i == 4) chk("shl_cnt4", cnt, 4'd4);
      if (i == 1) chk("shl_full7", full, 1'b0);
    end
    chk("shl_q", q, 8'hB2);
    chk("shl_cnt", cnt, 4'd8);
    chk("shl_full", full, 1'b1);
    sin = 1'b0;
    step();
    chk("shl9_cnt", cnt, 4'd8);
    chk("shl9_sout", sout, 1'b1);
    chk("shl9_full", full, 1'b1);
    chk("shl9_q", q, 8'h64);

    // load then shift right
    mode = 2'b11; ld = 8'hA5;
    step();
    chk("ld_q", q, 8'hA5);
    chk("ld_cnt", cnt, 4'd0);
    chk("ld_full", full, 1'b0);
    chk("ld_sout", sout, 1'b0);
    mode = 2'b01; sin = 1'b0;
    for (int i = 2; i >= 0; i--) begin
      step();
      chk("shr_sout", sout, exp_sout[i]);
    end
    chk("shr_q", q, 8'h14);
    chk("shr_cnt", cnt, 4'd3);

    // rotate does not count
    mode = 2'b11; ld = 8'h81;
    step();
    mode = 2'b10;
    step();
    chk("rol_q", q, 8'h03);
    chk("rol_sout", sout, 1'b1);
    chk("rol_cnt", cnt, 4'd0);
    chk("rol_full", full, 1'b0);

    // tap sweep while holding
    mode = 2'b11; ld = 8'h5A;
    step();
    en = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      #1;
      chk("z_sweep", z, v5a[s]);
      step();
      chk("zr_sweep", z_r, v5a[s]);
    end
    chk("hold_q", q, 8'h5A);

    // reset mid-word
    en = 1'b1; mode = 2'b11; ld = 8'h00;
    step();
    mode = 2'b00; sin = 1'b1; sel = 3'd0;
    for (int i = 0; i < 4; i++) step();
    chk("mid_cnt4", cnt, 4'd4);
    chk("mid_q", q, 8'h0F);
    rst_n = 1'b0;
    step();
    chk("mrst_q", q, 8'h00);
    chk("mrst_cnt", cnt, 4'd0);
    chk("mrst_sout", sout, 1'b0);
    chk("mrst_zr", z_r, 1'b0);
    chk("mrst_z", z, 1'b0);
    rst_n = 1'b1;
    step();
    chk("rest_cnt", cnt, 4'd1);
    chk("rest_q", q, 8'h01);
    chk("rest_zr", z_r, 1'b1);

    // WIDTH=6: out-of-range select and hold
    en6 = 1'b1; mode6 = 2'b11; ld6 = 6'b10_1101;
    step();
    chk("w6_ld", q6, 6'h2D);
    en6 = 1'b0;
    sel6 = 3'd6;
    #1;
    chk("w6_z6", z6, 1'b0);
    step();
    chk("w6_zr6", z6_r, 1'b0);
    sel6 = 3'd7;
    #1;
    chk("w6_z7", z6, 1'b0);
    step();
    chk("w6_zr7", z6_r, 1'b0);
    sel6 = 3'd5;
    #1;
    chk("w6_z5", z6, 1'b1);
    step();
    chk("w6_zr5", z6_r, 1'b1);
    en6 = 1'b1; mode6 = 2'b00; sin6 = 1'b1;
    step();
    chk("w6_shl_q", q6, 6'h1B);
    chk("w6_shl_sout", sout6, 1'b1);
    chk("w6_shl_cnt", cnt6, 3'd1);
    en6 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      mode6 = 2'(i);
      sin6 = ~sin6;
      ld6 = 6'h00;
      step();
    end
    chk("w6_hold_q", q6, 6'h1B);
    chk("w6_hold_cnt", cnt6, 3'd1);
    chk("w6_hold_sout", sout6, 1'b1);
    chk("w6_hold_full", full6, 1'b0);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
